// File: rtl/imem_load_ctrl.sv
// Boot/load sequencer: steers programmer writes into instruction or data memory
// and decides when the CPU fetch unit may run.
module imem_load_ctrl #(
  parameter int IADDR_W = 14,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               upg_rst_i,
  input  logic               upg_wen_i,
  input  logic [IADDR_W:0]   upg_adr_i,
  input  logic [DATA_W-1:0]  upg_dat_i,
  input  logic               upg_done_i,
  input  logic               run_i,
  output logic               imem_wen,
  output logic [IADDR_W-1:0] imem_adr,
  output logic               dmem_wen,
  output logic [DATA_W-1:0]  mem_dat,
  output logic [IADDR_W-1:0] dmem_adr,
  output logic               kick_off,
  output logic               inited,
  output logic               cpu_rst_o,
  output logic [IADDR_W:0]   word_cnt,
  output logic               load_err
);

  localparam int               TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [IADDR_W:0] CNT_MAX  = '1;
  localparam logic [IADDR_W:0] CNT_ONE  = {{IADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_HALT, S_LOAD, S_FLUSH, S_RUN, S_ERR} state_t;

  state_t           state;
  logic             upg_rst_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             load_start;
  logic             wr_p0;

  assign load_start = upg_rst_q & ~upg_rst_i;
  assign wr_p0      = (state == S_LOAD) & upg_wen_i;

  function automatic logic [IADDR_W:0] sat_inc(input logic [IADDR_W:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_HALT;
      upg_rst_q <= 1'b1;
      tmo_cnt   <= '0;
      imem_wen  <= 1'b0;
      dmem_wen  <= 1'b0;
      imem_adr  <= '0;
      dmem_adr  <= '0;
      mem_dat   <= '0;
      kick_off  <= 1'b0;
      inited    <= 1'b0;
      cpu_rst_o <= 1'b1;
      word_cnt  <= '0;
      load_err  <= 1'b0;
    end else begin
      upg_rst_q <= upg_rst_i;

      // p0 -> p1: programmer strobe registered into exactly one memory write
      imem_wen <= wr_p0 & ~upg_adr_i[IADDR_W];
      dmem_wen <= wr_p0 &  upg_adr_i[IADDR_W];
      if (wr_p0) begin
        mem_dat  <= upg_dat_i;
        word_cnt <= sat_inc(word_cnt);
        tmo_cnt  <= '0;
        if (upg_adr_i[IADDR_W]) dmem_adr <= upg_adr_i[IADDR_W-1:0];
        else                    imem_adr <= upg_adr_i[IADDR_W-1:0];
      end else if (state == S_LOAD) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      case (state)
        S_HALT: begin
          kick_off  <= 1'b0;
          inited    <= 1'b0;
          cpu_rst_o <= 1'b1;
          if (load_start) begin
            state    <= S_LOAD;
            word_cnt <= '0;
            load_err <= 1'b0;
            tmo_cnt  <= '0;
          end else if (run_i) begin
            state     <= S_RUN;
            kick_off  <= 1'b1;
            cpu_rst_o <= 1'b0;
          end
        end
        S_LOAD: begin
          if (upg_rst_i && !upg_done_i) begin
            state    <= S_HALT;
            load_err <= 1'b1;
          end else if (upg_done_i) begin
            state <= S_FLUSH;
          end else if (!wr_p0 && tmo_cnt == TMO_LAST) begin
            state    <= S_ERR;
            load_err <= 1'b1;
          end
        end
        S_FLUSH: begin
          state     <= S_RUN;
          kick_off  <= 1'b1;
          cpu_rst_o <= 1'b0;
        end
        S_RUN: begin
          // inited lags kick_off so the PC holds 0 for one reset-free cycle
          if (load_start) begin
            state     <= S_LOAD;
            kick_off  <= 1'b0;
            inited    <= 1'b0;
            cpu_rst_o <= 1'b1;
            word_cnt  <= '0;
            load_err  <= 1'b0;
            tmo_cnt   <= '0;
          end else begin
            inited <= 1'b1;
          end
        end
        S_ERR: begin
          load_err <= 1'b1;
          if (upg_rst_i) state <= S_HALT;
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed plus randomized bench for imem_load_ctrl against a per-cycle reference model.
module tb_imem_load_ctrl;

  localparam int TIMEOUT = 16;
  localparam int P_HALT = 0, P_LOAD = 1, P_FLUSH = 2, P_RUN = 3, P_ERR = 4;

  logic        clock, reset;
  logic        upg_rst_i, upg_wen_i, upg_done_i, run_i;
  logic [14:0] upg_adr_i;
  logic [31:0] upg_dat_i;
  logic        imem_wen, dmem_wen, kick_off, inited, cpu_rst_o, load_err;
  logic [13:0] imem_adr, dmem_adr;
  logic [31:0] mem_dat;
  logic [14:0] word_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_phase, m_idle, m_cnt;
  int          m_iadr, m_dadr;
  bit          m_q, m_iw, m_dw, m_kick, m_init, m_crst, m_err;
  logic [31:0] m_dat;

  imem_load_ctrl #(.IADDR_W(14), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .upg_rst_i(upg_rst_i), .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i),
    .upg_dat_i(upg_dat_i), .upg_done_i(upg_done_i), .run_i(run_i),
    .imem_wen(imem_wen), .imem_adr(imem_adr), .dmem_wen(dmem_wen),
    .mem_dat(mem_dat), .dmem_adr(dmem_adr), .kick_off(kick_off),
    .inited(inited), .cpu_rst_o(cpu_rst_o), .word_cnt(word_cnt),
    .load_err(load_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit ls, wr;
    int a;
    if (reset) begin
      m_phase = P_HALT; m_q = 1; m_iw = 0; m_dw = 0; m_iadr = 0; m_dadr = 0;
      m_dat = 0; m_kick = 0; m_init = 0; m_crst = 1; m_cnt = 0; m_err = 0; m_idle = 0;
      return;
    end
    ls = m_q && !upg_rst_i;
    wr = (m_phase == P_LOAD) && upg_wen_i;
    a  = int'(upg_adr_i);
    m_iw = wr && (a < 16384);
    m_dw = wr && (a >= 16384);
    if (wr) begin
      m_dat = upg_dat_i;
      if (a < 16384) m_iadr = a;
      else           m_dadr = a - 16384;
      if (m_cnt < 32767) m_cnt++;
    end
    case (m_phase)
      P_HALT: begin
        if (ls) begin
          m_phase = P_LOAD; m_cnt = 0; m_err = 0; m_idle = 0;
        end else if (run_i) begin
          m_phase = P_RUN; m_kick = 1; m_crst = 0;
        end
      end
      P_LOAD: begin
        if (upg_rst_i && !upg_done_i) begin
          m_phase = P_HALT; m_err = 1;
        end else if (upg_done_i) begin
          m_phase = P_FLUSH;
        end else if (!wr && m_idle == TIMEOUT - 1) begin
          m_phase = P_ERR; m_err = 1;
        end
        m_idle = wr ? 0 : m_idle + 1;
      end
      P_FLUSH: begin
        m_phase = P_RUN; m_kick = 1; m_crst = 0;
      end
      P_RUN: begin
        if (ls) begin
          m_phase = P_LOAD; m_kick = 0; m_init = 0; m_crst = 1;
          m_cnt = 0; m_err = 0; m_idle = 0;
        end else begin
          m_init = 1;
        end
      end
      default: if (upg_rst_i) m_phase = P_HALT;
    endcase
    m_q = upg_rst_i;
  endtask

  task automatic check_outputs();
    chk("imem_wen", imem_wen, m_iw);
    chk("dmem_wen", dmem_wen, m_dw);
    chk("imem_adr", imem_adr, m_iadr);
    chk("dmem_adr", dmem_adr, m_dadr);
    chk("mem_dat", mem_dat, m_dat);
    chk("kick_off", kick_off, m_kick);
    chk("inited", inited, m_init);
    chk("cpu_rst_o", cpu_rst_o, m_crst);
    chk("word_cnt", word_cnt, m_cnt);
    chk("load_err", load_err, m_err);
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [14:0] adr, input logic [31:0] dat);
    upg_wen_i = 1'b1; upg_adr_i = adr; upg_dat_i = dat;
    cyc();
    upg_wen_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; upg_rst_i = 1'b1; upg_wen_i = 1'b0; upg_done_i = 1'b0;
    run_i = 1'b0; upg_adr_i = '0; upg_dat_i = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_cpu_rst", cpu_rst_o, 1); chk("rst_kick", kick_off, 0);
    chk("rst_inited", inited, 0);     chk("rst_cnt", word_cnt, 0);

    // run without loading
    run_i = 1'b1; cyc(); run_i = 1'b0;
    chk("run_kick", kick_off, 1); chk("run_cpu_rst", cpu_rst_o, 0); chk("run_inited0", inited, 0);
    cyc();
    chk("run_inited1", inited, 1);

    // three-word load
    upg_rst_i = 1'b0; cyc();
    chk("ld_kick", kick_off, 0); chk("ld_cpu_rst", cpu_rst_o, 1); chk("ld_inited", inited, 0);
    wr(15'h0000, 32'hA);
    chk("w0_iwen", imem_wen, 1); chk("w0_adr", imem_adr, 0); chk("w0_dat", mem_dat, 32'hA);
    wr(15'h0001, 32'hB);
    chk("w1_iwen", imem_wen, 1); chk("w1_adr", imem_adr, 1);
    wr(15'h4002, 32'hC);
    chk("w2_dwen", dmem_wen, 1); chk("w2_iwen", imem_wen, 0);
    chk("w2_adr", dmem_adr, 2); chk("w2_dat", mem_dat, 32'hC); chk("w2_cnt", word_cnt, 3);
    upg_done_i = 1'b1; cyc(); upg_done_i = 1'b0;
    chk("flush_cpu_rst", cpu_rst_o, 1); chk("flush_kick", kick_off, 0);
    cyc();
    chk("post_flush_kick", kick_off, 1); chk("post_flush_rst", cpu_rst_o, 0);
    upg_rst_i = 1'b1; cyc(); cyc();

    // write coinciding with done
    upg_rst_i = 1'b0; cyc();
    upg_wen_i = 1'b1; upg_adr_i = 15'h0005; upg_dat_i = 32'h55; upg_done_i = 1'b1;
    cyc();
    upg_wen_i = 1'b0; upg_done_i = 1'b0;
    chk("dw_iwen", imem_wen, 1); chk("dw_adr", imem_adr, 5); chk("dw_cnt", word_cnt, 1);
    chk("dw_flush_rst", cpu_rst_o, 1);
    cyc();
    chk("dw_run_kick", kick_off, 1);

    // timeout into ERR
    upg_rst_i = 1'b1; cyc();
    upg_rst_i = 1'b0; cyc();
    wr(15'h4010, 32'h1234_5678);
    repeat (TIMEOUT - 1) cyc();
    chk("tmo_early_err", load_err, 0);
    cyc();
    chk("tmo_err", load_err, 1); chk("tmo_kick", kick_off, 0);
    cyc();
    upg_rst_i = 1'b1; cyc();
    chk("err_halt_err", load_err, 1); cyc();
    chk("err_halt_err2", load_err, 1);
    upg_rst_i = 1'b0; cyc();
    chk("err_cleared", load_err, 0); chk("err_cnt_cleared", word_cnt, 0);

    // reload from RUN, then abort
    upg_done_i = 1'b1; cyc(); upg_done_i = 1'b0;
    cyc(); cyc();
    chk("run2_inited", inited, 1);
    upg_rst_i = 1'b1; cyc();
    upg_rst_i = 1'b0; cyc();
    chk("reld_kick", kick_off, 0); chk("reld_inited", inited, 0); chk("reld_rst", cpu_rst_o, 1);
    upg_rst_i = 1'b1; cyc();
    chk("abort_err", load_err, 1); chk("abort_kick", kick_off, 0);

    // reset during a write
    upg_rst_i = 1'b0; cyc();
    wr(15'h0007, 32'h77);
    reset = 1'b1; upg_wen_i = 1'b1; upg_adr_i = 15'h0003; upg_dat_i = 32'h99;
    cyc();
    reset = 1'b0; upg_wen_i = 1'b0; upg_rst_i = 1'b1;
    chk("rstw_iwen", imem_wen, 0); chk("rstw_cnt", word_cnt, 0); chk("rstw_dat", mem_dat, 0);
    cyc();

    // strobes outside LOAD
    run_i = 1'b1; cyc(); run_i = 1'b0;
    upg_wen_i = 1'b1; upg_adr_i = 15'h0011; cyc(); cyc(); upg_wen_i = 1'b0;
    chk("run_wen_ignored", imem_wen, 0); chk("run_cnt", word_cnt, 0);

    // word counter saturation
    upg_rst_i = 1'b0; cyc();
    for (int i = 0; i < 32770; i++) begin
      upg_wen_i = 1'b1;
      upg_adr_i = 15'($urandom);
      upg_dat_i = $urandom;
      cyc();
    end
    upg_wen_i = 1'b0;
    chk("sat_cnt", word_cnt, 32767);
    upg_done_i = 1'b1; cyc(); upg_done_i = 1'b0;
    upg_rst_i = 1'b1; cyc(); cyc();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) upg_rst_i = ~upg_rst_i;
      upg_wen_i  = $urandom_range(0, 1) == 1;
      upg_adr_i  = 15'($urandom);
      upg_dat_i  = $urandom;
      upg_done_i = ($urandom_range(0, 24) == 0);
      run_i      = ($urandom_range(0, 39) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Boot/load sequencer for the program ROM and data RAM. It owns the UART-programmer write path and decides when the CPU fetch unit may run. Programmer writes are steered to instruction or data memory by address bit 14. The block generates the run (kick-off) and inited qualifiers consumed by the instruction fetch unit, and holds the CPU in reset while memories are being rewritten. All upg_* inputs are already synchronised to clock upstream.

Parameters:
IADDR_W, 14, word-address width of instruction and data memories
DATA_W, 32, memory word width
TIMEOUT, 1000000, cycles without a write in LOAD before declaring error

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
upg_rst_i  in  1  programmer idle (1) / active (0)
upg_wen_i  in  1  programmer write strobe, one cycle per word
upg_adr_i  in  15  [14]=0 imem, [14]=1 dmem; [13:0] word address
upg_dat_i  in  32  write data
upg_done_i  in  1  programmer finished, level
run_i  in  1  single-cycle pulse: start CPU from HALT without loading
imem_wen  out  1  instruction memory write enable
imem_adr  out  14  instruction memory word address
dmem_wen  out  1  data memory write enable
mem_dat  out  32  write data, shared by both memories
dmem_adr  out  14  data memory word address
kick_off  out  1  1 = CPU owns the ROM port
inited  out  1  1 = fetch may advance PC
cpu_rst_o  out  1  reset to the CPU core
word_cnt  out  15  words written in current/last load
load_err  out  1  sticky error flag

Behaviour:
- States: HALT, LOAD, FLUSH, RUN, ERR. Reset -> HALT.
- Reset values: all write enables 0, addresses/data 0, kick_off 0, inited 0, cpu_rst_o 1, word_cnt 0, load_err 0, timeout counter 0, upg_rst_q 1.
- upg_rst_q = registered upg_rst_i. load_start = upg_rst_q & ~upg_rst_i (falling edge).
- HALT: kick_off 0, inited 0, cpu_rst_o 1. load_start -> LOAD (clear word_cnt, load_err, timeout). Else run_i -> RUN. If load_start and run_i coincide, LOAD wins.
- LOAD: kick_off 0, cpu_rst_o 1. Each upg_wen_i registers to one write next cycle (latency 1): adr[14]=0 -> imem_wen=1, imem_adr=adr[13:0]; adr[14]=1 -> dmem_wen=1, dmem_adr=adr[13:0]; mem_dat=upg_dat_i. Never both enables in one cycle. word_cnt += 1 per write, saturating at 32767. Timeout counter clears on each write, else increments.
- LOAD exits, priority order: upg_rst_i=1 without upg_done_i -> HALT, load_err=1 (abort). upg_done_i=1 -> FLUSH (a write in that same cycle is still performed). Timeout counter reaching TIMEOUT-1 -> ERR.
- FLUSH: one cycle, no writes, cpu_rst_o 1, drains the final registered write -> RUN.
- RUN: kick_off 1 and cpu_rst_o 0 from the first RUN cycle. inited rises one cycle later, so the PC sees one reset-free cycle at 0 before advancing. upg_wen_i is ignored. load_start -> LOAD; in that same transition kick_off, inited = 0 and cpu_rst_o = 1.
- ERR: kick_off 0, cpu_rst_o 1, load_err 1. upg_rst_i=1 -> HALT with load_err held. load_err clears only on the next load_start or on reset.
- upg_wen_i outside LOAD produces no write and no count change.
- reset in any state, including mid-write: the pending write is dropped and all outputs return to reset values the next cycle.

Test Plan:
- Reset, then run_i pulse -> kick_off=1 and cpu_rst_o=0 next cycle, inited=1 one cycle after that; no write enables at any time.
- upg_rst_i 1->0, three writes to adr 0x0000, 0x0001, 0x4002 with data 0xA, 0xB, 0xC, then upg_done_i -> imem writes at 0 and 1, one dmem write at 2, each 1 cycle after its strobe; word_cnt=3; FLUSH 1 cycle, then RUN.
- Write strobe in the same cycle as upg_done_i (adr 0x0005) -> write still issued, word_cnt counts it, FLUSH follows.
- With TIMEOUT=16: enter LOAD, one write, then 16 idle cycles -> ERR, load_err=1, kick_off=0. Raise upg_rst_i -> HALT, load_err still 1. Next load_start clears it.
- In RUN, drop upg_rst_i -> kick_off and inited fall on the transition edge, cpu_rst_o=1. upg_rst_i back to 1 without done -> HALT with load_err=1.
- Assert reset during LOAD concurrent with upg_wen_i -> no write issued next cycle, word_cnt=0, state HALT.
